// File: rtl/softfloat_pkg.sv
// Shared softfloat constants: exception flag bits, binary64 field geometry,
// one-hot FSM encodings and operand classification.
package softfloat_pkg;

    localparam logic [31:0] INEXACT   = 32'd1;
    localparam logic [31:0] DIVBYZERO = 32'd2;
    localparam logic [31:0] UNDERFLOW = 32'd4;
    localparam logic [31:0] OVERFLOW  = 32'd8;
    localparam logic [31:0] INVALID   = 32'd16;

    localparam logic [10:0] EXP_MAX    = 11'h7FF;
    localparam int          FRAC_W     = 52;
    localparam int          ROUND_BITS = 10;

    localparam logic [3:0] ST1 = 4'b0001;
    localparam logic [3:0] ST2 = 4'b0010;
    localparam logic [3:0] ST3 = 4'b0100;
    localparam logic [3:0] ST4 = 4'b1000;

    typedef struct packed {
        logic zero;
        logic inf;
        logic nan;
        logic snan;
    } class_t;

    function automatic class_t classify(input logic [63:0] op);
        class_t c;
        c.zero = (op[62:52] == 11'd0)     && (op[51:0] == 52'd0);
        c.inf  = (op[62:52] == EXP_MAX)   && (op[51:0] == 52'd0);
        c.nan  = (op[62:52] == EXP_MAX)   && (op[51:0] != 52'd0);
        c.snan = c.nan && !op[51];
        return c;
    endfunction

    function automatic logic is_subnormal(input logic [63:0] op);
        return (op[62:52] == 11'd0) && (op[51:0] != 52'd0);
    endfunction

endpackage

// File: rtl/clz64.sv
// Combinational 64-bit leading-zero counter; an all-zero input returns 64.
module clz64 (
    input  logic [63:0] i_x,
    output logic [6:0]  o_cnt
);

    always_comb begin
        o_cnt = 7'd64;
        // Ascending scan: the highest set bit is the last one to write.
        for (int i = 0; i < 64; i++) begin
            if (i_x[i]) begin
                o_cnt = 7'(63 - i);
            end
        end
    end

endmodule

// File: rtl/unpack_float64.sv
// binary64 unpack front end: splits and classifies the operand, normalising
// subnormals over two extra cycles, with an ap_ctrl_hs block handshake.
module unpack_float64
    import softfloat_pkg::*;
#(
    parameter int EXP_W = 12,
    parameter int SIG_W = 64
) (
    input  logic             ap_clk,
    input  logic             ap_rst_n,
    input  logic             ap_start,
    output logic             ap_done,
    output logic             ap_idle,
    output logic             ap_ready,
    input  logic [63:0]      a,
    input  logic [31:0]      float_exception_flag_i,
    output logic [31:0]      float_exception_flag_o,
    output logic             float_exception_flag_o_ap_vld,
    output logic             zSign,
    output logic [EXP_W-1:0] zExp,
    output logic [SIG_W-1:0] zSig,
    output logic             is_zero,
    output logic             is_inf,
    output logic             is_nan,
    output logic             is_snan
);

    logic [3:0]        r_state;
    logic [3:0]        w_state_next;
    logic [FRAC_W-1:0] r_frac;
    logic [6:0]        r_clz;
    logic              r_sign,     r_hold_sign;
    logic [EXP_W-1:0]  r_exp,      r_hold_exp;
    logic [SIG_W-1:0]  r_sig,      r_hold_sig;
    class_t            r_cls,      r_hold_cls;

    logic              w_st1, w_st2, w_st3, w_st4;
    logic              w_cap, w_in_sub, w_flag_set;
    class_t            w_in_cls, w_out_cls;
    logic [EXP_W-1:0]  w_cap_exp;
    logic [SIG_W-1:0]  w_cap_sig;
    logic [6:0]        w_clz, w_sc;
    logic [63:0]       w_sub_sig;

    assign w_st1    = r_state[0];
    assign w_st2    = r_state[1];
    assign w_st3    = r_state[2];
    assign w_st4    = r_state[3];
    assign w_cap    = w_st1 & ap_start;
    assign w_in_cls = classify(a);
    assign w_in_sub = is_subnormal(a);

    clz64 u_clz (
        .i_x   ({12'd0, r_frac}),
        .o_cnt (w_clz)
    );

    // Shift so the leading one of the fraction lands on the hidden-bit position.
    assign w_sc      = r_clz - 7'd11;
    assign w_sub_sig = (64'(r_frac) << w_sc) << ROUND_BITS;

    always_comb begin
        w_cap_exp = '0;
        w_cap_sig = '0;
        if (w_in_cls.inf || w_in_cls.nan) begin
            w_cap_exp = EXP_W'(EXP_MAX);
            w_cap_sig = SIG_W'(64'(a[51:0]) << ROUND_BITS);
        end else if (a[62:52] != 11'd0) begin
            w_cap_exp = EXP_W'(a[62:52]) - EXP_W'(1);
            w_cap_sig = SIG_W'(64'({1'b1, a[51:0]}) << ROUND_BITS);
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST1:     if (ap_start) w_state_next = w_in_sub ? ST2 : ST4;
            ST2:     w_state_next = ST3;
            ST3:     w_state_next = ST4;
            ST4:     w_state_next = ST1;
            default: w_state_next = ST1;
        endcase
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            r_state     <= ST1;
            r_frac      <= '0;
            r_clz       <= '0;
            r_sign      <= 1'b0;
            r_exp       <= '0;
            r_sig       <= '0;
            r_cls       <= '0;
            r_hold_sign <= 1'b0;
            r_hold_exp  <= '0;
            r_hold_sig  <= '0;
            r_hold_cls  <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_cap) begin
                r_frac <= a[51:0];
                r_sign <= a[63];
                r_exp  <= w_cap_exp;
                r_sig  <= w_cap_sig;
                r_cls  <= w_in_cls;
            end
            if (w_st2) begin
                r_clz <= w_clz;
            end
            if (w_st3) begin
                r_exp <= EXP_W'(0) - EXP_W'(w_sc);
                r_sig <= SIG_W'(w_sub_sig);
            end
            if (w_st4) begin
                r_hold_sign <= r_sign;
                r_hold_exp  <= r_exp;
                r_hold_sig  <= r_sig;
                r_hold_cls  <= r_cls;
            end
        end
    end

    assign zSign     = w_st4 ? r_sign : r_hold_sign;
    assign zExp      = w_st4 ? r_exp  : r_hold_exp;
    assign zSig      = w_st4 ? r_sig  : r_hold_sig;
    assign w_out_cls = w_st4 ? r_cls  : r_hold_cls;
    assign is_zero   = w_out_cls.zero;
    assign is_inf    = w_out_cls.inf;
    assign is_nan    = w_out_cls.nan;
    assign is_snan   = w_out_cls.snan;

    assign ap_done  = w_st4 | (w_st1 & ~ap_start);
    assign ap_ready = w_st4;
    assign ap_idle  = w_st1 & ~ap_start;

    // Signalling NaNs raise invalid only in the cycle the operand is accepted.
    assign w_flag_set                    = w_cap & w_in_cls.snan;
    assign float_exception_flag_o        = float_exception_flag_i | (w_flag_set ? INVALID : 32'd0);
    assign float_exception_flag_o_ap_vld = w_flag_set;

endmodule

// File: tb/tb_unpack_float64.sv
// Randomised scoreboard bench for unpack_float64 with a value-level reference
// model and a pack-stage round-trip check.
module tb_unpack_float64;

    logic        ap_clk = 1'b0;
    logic        ap_rst_n, ap_start;
    logic        ap_done, ap_idle, ap_ready;
    logic [63:0] a;
    logic [31:0] flag_i, flag_o;
    logic        flag_vld;
    logic        zSign;
    logic [11:0] zExp;
    logic [63:0] zSig;
    logic        is_zero, is_inf, is_nan, is_snan;

    unpack_float64 dut (
        .ap_clk                        (ap_clk),
        .ap_rst_n                      (ap_rst_n),
        .ap_start                      (ap_start),
        .ap_done                       (ap_done),
        .ap_idle                       (ap_idle),
        .ap_ready                      (ap_ready),
        .a                             (a),
        .float_exception_flag_i        (flag_i),
        .float_exception_flag_o        (flag_o),
        .float_exception_flag_o_ap_vld (flag_vld),
        .zSign                         (zSign),
        .zExp                          (zExp),
        .zSig                          (zSig),
        .is_zero                       (is_zero),
        .is_inf                        (is_inf),
        .is_nan                        (is_nan),
        .is_snan                       (is_snan)
    );

    always #5 ap_clk = ~ap_clk;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;
    always @(posedge ap_clk) cyc <= cyc + 1;

    typedef struct packed {
        logic [63:0] a;
        logic        s;
        logic [11:0] ze;
        logic [63:0] zs;
        logic [3:0]  cls;   // {zero, inf, nan, snan}
        int          issue;
        int          lat;
    } exp_t;

    exp_t        q[$];
    logic [80:0] last;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h required %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Reference: value-level decomposition of a binary64 operand.
    function automatic exp_t model(input logic [63:0] op);
        exp_t        x;
        logic [51:0] f;
        int          e, p;
        x     = '0;
        x.a   = op;
        x.s   = op[63];
        f     = op[51:0];
        e     = int'(op[62:52]);
        x.lat = 1;
        if (e == 2047) begin
            x.ze  = 12'h7FF;
            x.zs  = 64'(f) * 64'd1024;
            x.cls = {1'b0, f == 52'd0, f != 52'd0, (f != 52'd0) && !f[51]};
        end else if (e == 0 && f == 52'd0) begin
            x.cls = 4'b1000;
        end else if (e == 0) begin
            p = 0;
            for (int i = 0; i < 52; i++) if (f[i]) p = i;
            x.ze  = 12'(p - 52);
            x.zs  = 64'(f) << (62 - p);
            x.lat = 3;
        end else begin
            x.ze = 12'(e - 1);
            x.zs = (64'(f) + (64'd1 << 52)) * 64'd1024;
        end
        return x;
    endfunction

    // Exact-value pack (no rounding needed for unpacked operands).
    function automatic logic [63:0] pack_model(input logic s, input logic [11:0] ze, input logic [63:0] zs);
        logic [63:0] sig;
        int          e;
        sig = zs;
        e   = int'($signed(ze));
        if (e < 0) begin
            sig = sig >> (-e);
            e   = 0;
        end
        return {s, 63'd0} + (64'(e) << 52) + (sig >> 10);
    endfunction

    function automatic logic [63:0] rand_op();
        logic [63:0] r;
        logic [51:0] f;
        r = {$urandom, $urandom};
        f = r[51:0];
        case ($urandom_range(0, 5))
            0, 1: return {r[63], 11'($urandom_range(1, 2046)), f};
            2: begin
                f = f >> $urandom_range(0, 51);
                if (f == 52'd0) f = 52'd1;
                return {r[63], 11'd0, f};
            end
            3: return {r[63], 63'd0};
            4: begin
                if ($urandom_range(0, 2) == 0) f = 52'd0;
                return {r[63], 11'h7FF, f};
            end
            default: return r;
        endcase
    endfunction

    // Monitor: pops the scoreboard on every ap_ready and checks hold behaviour otherwise.
    exp_t        mon_e;
    logic [80:0] mon_act;
    always @(negedge ap_clk) begin
        mon_act = {zSign, zExp, zSig, is_zero, is_inf, is_nan, is_snan};
        if (!ap_rst_n) begin
            last = '0;
        end else if (ap_ready) begin
            if (q.size() == 0) begin
                chk("unexpected_done", 128'(mon_act), 128'd0);
            end else begin
                mon_e = q.pop_front();
                chk("result", 128'(mon_act), 128'({mon_e.s, mon_e.ze, mon_e.zs, mon_e.cls}));
                chk("latency", 128'(cyc), 128'(mon_e.issue + mon_e.lat));
                chk("flag_in_done", 128'({flag_vld, flag_o}), 128'({1'b0, flag_i}));
                if (!is_inf && !is_nan)
                    chk("roundtrip", 128'(pack_model(zSign, zExp, zSig)), 128'(mon_e.a));
                $display("txn a=%h zSign=%0d zExp=%h zSig=%h cls=%b lat=%0d",
                         mon_e.a, zSign, zExp, zSig, mon_act[3:0], cyc - mon_e.issue);
                last = {mon_e.s, mon_e.ze, mon_e.zs, mon_e.cls};
            end
        end else begin
            chk("hold", 128'(mon_act), 128'(last));
        end
    end

    // Issue one operand in ST1; optionally idle one cycle first.
    task automatic issue(input logic [63:0] op, input bit gap);
        exp_t        e;
        logic [31:0] fi;
        bit          seen;
        if (gap) begin
            ap_start = 1'b0;
            @(negedge ap_clk);
            chk("idle_status", 128'({ap_idle, ap_done, ap_ready}), 128'(3'b110));
            @(posedge ap_clk); #1;
        end
        fi       = $urandom;
        a        = op;
        flag_i   = fi;
        ap_start = 1'b1;
        e        = model(op);
        @(negedge ap_clk);
        chk("start_cycle", 128'({ap_idle, ap_done, flag_vld, flag_o}),
            128'({1'b0, 1'b0, e.cls[0], fi | (e.cls[0] ? 32'd16 : 32'd0)}));
        e.issue = cyc;
        q.push_back(e);
        @(posedge ap_clk); #1;
        a      = {$urandom, $urandom};
        flag_i = $urandom;
        seen   = 1'b0;
        for (int k = 0; k < 8 && !seen; k++) begin
            @(negedge ap_clk);
            if (ap_ready) seen = 1'b1;
        end
        if (!seen) begin
            chk("done_timeout", 128'd0, 128'd1);
            q.delete();
        end
        @(posedge ap_clk); #1;
    endtask

    logic [63:0] dir [9];

    initial begin
        dir[0] = 64'h3FF0000000000000;
        dir[1] = 64'h0000000000000001;
        dir[2] = 64'h7FF0000000000001;
        dir[3] = 64'h8000000000000000;
        dir[4] = 64'hFFF0000000000000;
        dir[5] = 64'h7FF8000000000000;
        dir[6] = 64'h000FFFFFFFFFFFFF;
        dir[7] = 64'h7FEFFFFFFFFFFFFF;
        dir[8] = 64'h0010000000000000;

        ap_rst_n = 1'b0;
        ap_start = 1'b0;
        a        = '0;
        flag_i   = '0;
        repeat (2) @(posedge ap_clk);
        @(negedge ap_clk);
        chk("reset_state",
            128'({zSign, zExp, zSig, is_zero, is_inf, is_nan, is_snan, ap_ready, ap_idle, ap_done, flag_vld, flag_o}),
            128'({81'd0, 1'b0, 1'b1, 1'b1, 1'b0, 32'd0}));
        @(posedge ap_clk); #1;
        ap_rst_n = 1'b1;
        @(posedge ap_clk); #1;

        for (int i = 0; i < 9; i++) issue(dir[i], (i % 2) == 1);

        // Abort a subnormal in ST2 with reset; nothing may complete for it.
        ap_start = 1'b0;
        @(posedge ap_clk); #1;
        a        = 64'h0000000000000003;
        flag_i   = 32'h5;
        ap_start = 1'b1;
        @(posedge ap_clk); #1;
        ap_start = 1'b0;
        ap_rst_n = 1'b0;
        @(negedge ap_clk);
        chk("reset_abort",
            128'({zSign, zExp, zSig, is_zero, is_inf, is_nan, is_snan, ap_ready, ap_idle, ap_done, flag_vld, flag_o}),
            128'({81'd0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h5}));
        @(posedge ap_clk); #1;
        ap_rst_n = 1'b1;
        @(posedge ap_clk); #1;
        issue(64'hC000000000000000, 1'b0);

        for (int i = 0; i < 2500; i++) issue(rand_op(), $urandom_range(0, 1) == 1);

        ap_start = 1'b0;
        repeat (4) @(posedge ap_clk);
        #1;
        chk("scoreboard_drained", 128'(q.size()), 128'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
